toggle_debounce: RTL

- Upstream conditioning stage for the T flip-flop (`tff`). Takes a raw, asynchronous, bouncy push-button/switch level and synchronises it into `clk`.
- Qualifies the level by stability time and emits a clean single-cycle `t` pulse on each qualified press, so one press toggles `y` exactly once.
- Also exports the debounced level, a release pulse and a busy flag for downstream counters and status logic.

---
 rtl/toggle_debounce.sv | 92 +++++++++
 1 files changed

// File: rtl/toggle_debounce.sv
// toggle_debounce: synchronise a bouncy button, qualify by stability time, emit press/release pulses
module toggle_debounce #(
   parameter int SYNC_STAGES = 2,
   parameter int STABLE_CNT  = 1000,
   parameter int CNT_W       = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic t,
   output logic fall_pulse,
   output logic btn_level,
   output logic busy
);
   typedef enum logic [1:0] {IDLE_LOW, WAIT_HIGH, IDLE_HIGH, WAIT_LOW} state_t;
   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
      $error("toggle_debounce: SYNC_STAGES must be 2..4");
   end
   if (STABLE_CNT < 1 || (2 ** CNT_W) <= STABLE_CNT) begin : g_bad_cnt
      $error("toggle_debounce: need STABLE_CNT >= 1 and 2**CNT_W > STABLE_CNT");
   end
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CNT);
   logic [SYNC_STAGES-1:0] sync;
   logic                   s;
   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   assign s = sync[SYNC_STAGES-1];
   // bring the raw level into the clk domain
   always_ff @(posedge clk)
      sync <= !reset_n ? '0 : {sync[SYNC_STAGES-2:0], btn_in};
   // qualify each level change by STABLE_CNT+1 consecutive matching samples
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE_LOW;
         cnt        <= '0;
         t          <= 1'b0;
         fall_pulse <= 1'b0;
         btn_level  <= 1'b0;
         busy       <= 1'b0;
      end else begin
         t          <= 1'b0;
         fall_pulse <= 1'b0;
         case (state)
            IDLE_LOW: begin
               state <= s ? WAIT_HIGH : IDLE_LOW;
               cnt   <= s ? CNT_W'(1) : '0;
               busy  <= s;
            end
            WAIT_HIGH: begin
               if (!s) begin
                  state <= IDLE_LOW;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == LAST) begin
                  state     <= IDLE_HIGH;
                  cnt       <= '0;
                  busy      <= 1'b0;
                  btn_level <= 1'b1;
                  t         <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            IDLE_HIGH: begin
               state <= !s ? WAIT_LOW : IDLE_HIGH;
               cnt   <= !s ? CNT_W'(1) : '0;
               busy  <= !s;
            end
            WAIT_LOW: begin
               if (s) begin
                  state <= IDLE_HIGH;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt == LAST) begin
                  state      <= IDLE_LOW;
                  cnt        <= '0;
                  busy       <= 1'b0;
                  btn_level  <= 1'b0;
                  fall_pulse <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= IDLE_LOW;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end
endmodule
